// File: rtl/ahb_burst_master.sv
// ahb_burst_master: AHB-Lite master that turns simple commands into SINGLE/INCR
// bursts for the downstream AHB-to-APB bridge.
// Optional statistics counters are enabled with the macro AHB_MASTER_STATS_EN.
//
// Command handshake: a command transfers on a rising Hclk edge where
// cmd_valid && cmd_ready; cmd_ready is only high in IDLE, and the requester
// must hold the command fields stable while cmd_valid is high. Write data
// transfers on every edge where wr_ready is high (no back-pressure from the
// requester); read data is offered for one cycle on rd_valid.
module ahb_burst_master #(
  parameter int WIDTH   = 32,
  parameter int MAX_LEN = 16
) (
  input  logic             Hclk,
  input  logic             Hresetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [WIDTH-1:0] cmd_addr,
  input  logic [4:0]       cmd_len,
  input  logic [2:0]       cmd_size,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             err,
  output logic             busy,
  input  logic             Hready,
  input  logic [1:0]       Hresp,
  input  logic [WIDTH-1:0] Hrdata,
  output logic [1:0]       Htrans,
  output logic [2:0]       Hsize,
  output logic [WIDTH-1:0] Haddr,
  output logic             Hwrite,
  output logic [WIDTH-1:0] Hwdata,
`ifdef AHB_MASTER_STATS_EN
  input  logic             stats_clr,
  output logic [15:0]      beat_count,
  output logic [7:0]       err_count,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_LAST = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] TR_IDLE    = 2'b00;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [4:0]       MAX_LEN_L = 5'(MAX_LEN);

  state_t             state_q;
  logic [1:0]         htrans_q;
  logic [WIDTH-1:0]   haddr_q;
  logic [2:0]         hsize_q;
  logic               hwrite_q;
  logic [WIDTH-1:0]   hwdata_q;
  logic [WIDTH-1:0]   rd_data_q;
  logic               rd_valid_q;
  logic               err_q;
  logic               busy_q;
  logic               cmd_ready_q;
  logic [4:0]         addr_cnt_q;
  logic [4:0]         data_cnt_q;
  // A data phase is outstanding on the bus (previous address phase accepted).
  logic               dphase_q;

  // Command normalisation: len 0 means one beat, long bursts clamp, size caps at word.
  logic [4:0]         len_d;
  logic [2:0]         size_d;
  logic [WIDTH-1:0]   start_addr_d;
  logic [WIDTH-1:0]   next_addr_d;
  logic               in_xfer;
  logic               err_hit;
  logic               addr_accept;

  assign len_d        = (cmd_len == 5'd0) ? 5'd1 :
                        (cmd_len > MAX_LEN_L) ? MAX_LEN_L : cmd_len;
  assign size_d       = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
  assign start_addr_d = cmd_addr & ~((ONE << size_d) - ONE);
  assign next_addr_d  = haddr_q + (ONE << hsize_q);

  assign in_xfer     = (state_q == S_ADDR) || (state_q == S_LAST);
  // First cycle of a two-cycle ERROR response on the outstanding data phase.
  assign err_hit     = in_xfer && dphase_q && !Hready && (Hresp == RESP_ERROR);
  // In ADDR the bus always carries an active transfer, so Hready alone accepts it.
  assign addr_accept = (state_q == S_ADDR) && Hready;

  assign wr_ready  = addr_accept && hwrite_q;
  assign cmd_ready = cmd_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign Htrans    = htrans_q;
  assign Hsize     = hsize_q;
  assign Haddr     = haddr_q;
  assign Hwrite    = hwrite_q;
  assign Hwdata    = hwdata_q;
  assign dbg_state = state_q;

  // Burst FSM: command accept, address/data phase pipelining, abort on ERROR.
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q     <= S_IDLE;
      htrans_q    <= TR_IDLE;
      haddr_q     <= '0;
      hsize_q     <= 3'd0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      addr_cnt_q  <= 5'd0;
      data_cnt_q  <= 5'd0;
      dphase_q    <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            state_q     <= S_ADDR;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            htrans_q    <= TR_NONSEQ;
            haddr_q     <= start_addr_d;
            hsize_q     <= size_d;
            hwrite_q    <= cmd_write;
            addr_cnt_q  <= len_d;
            data_cnt_q  <= len_d;
          end
        end
        S_ADDR, S_LAST: begin
          if (err_hit) begin
            // Drop the pending address phase and every remaining beat.
            htrans_q <= TR_IDLE;
            state_q  <= S_ERR;
          end else if (Hready) begin
            if (dphase_q) begin
              data_cnt_q <= data_cnt_q - 5'd1;
              if (!hwrite_q && (Hresp == RESP_OKAY)) begin
                rd_data_q  <= Hrdata;
                rd_valid_q <= 1'b1;
              end
            end
            if (state_q == S_ADDR) begin
              dphase_q   <= 1'b1;
              addr_cnt_q <= addr_cnt_q - 5'd1;
              if (hwrite_q) begin
                hwdata_q <= wr_data;
              end
              if (addr_cnt_q == 5'd1) begin
                htrans_q <= TR_IDLE;
                state_q  <= S_LAST;
              end else begin
                haddr_q  <= next_addr_d;
                // A 1 KB boundary crossing restarts the burst as NONSEQ.
                htrans_q <= (next_addr_d[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
              end
            end else if (data_cnt_q == 5'd1) begin
              state_q     <= S_IDLE;
              dphase_q    <= 1'b0;
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
            end
          end
        end
        S_ERR: begin
          if (Hready) begin
            err_q       <= 1'b1;
            state_q     <= S_IDLE;
            dphase_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            htrans_q    <= TR_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AHB_MASTER_STATS_EN
  logic [15:0] beat_cnt_q;
  logic [7:0]  err_cnt_q;
  logic        beat_ok;
  logic        abort_ev;

  assign beat_ok    = in_xfer && dphase_q && Hready && (Hresp == RESP_OKAY);
  assign abort_ev   = (state_q == S_ERR) && Hready;
  assign beat_count = beat_cnt_q;
  assign err_count  = err_cnt_q;

  // Saturating beat/abort counters; clear has priority over counting.
  always_ff @(posedge Hclk) begin
    if (!Hresetn || stats_clr) begin
      beat_cnt_q <= 16'd0;
      err_cnt_q  <= 8'd0;
    end else begin
      if (beat_ok && (beat_cnt_q != 16'hFFFF)) begin
        beat_cnt_q <= beat_cnt_q + 16'd1;
      end
      if (abort_ev && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master. Inputs change 1 ns after the rising
// edge; outputs are checked on the falling edge.
module tb_ahb_burst_master;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [4:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        err;
  logic        busy;
  logic        Hready = 1'b1;
  logic [1:0]  Hresp = 2'b00;
  logic [31:0] Hrdata = '0;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize;
  logic [31:0] Haddr;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic [1:0]  dbg_state;
`ifdef AHB_MASTER_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] beat_count;
  logic [7:0]  err_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  ahb_burst_master #(.WIDTH(32), .MAX_LEN(16)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .err(err), .busy(busy),
    .Hready(Hready), .Hresp(Hresp), .Hrdata(Hrdata),
    .Htrans(Htrans), .Hsize(Hsize), .Haddr(Haddr), .Hwrite(Hwrite), .Hwdata(Hwdata),
`ifdef AHB_MASTER_STATS_EN
    .stats_clr(stats_clr), .beat_count(beat_count), .err_count(err_count),
`endif
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 Hclk = ~Hclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge Hclk);
    #1;
  endtask

  task automatic sample();
    @(negedge Hclk);
  endtask

  // Driver: present one command in an IDLE cycle; leaves time in the first ADDR cycle.
  task automatic issue_cmd(input logic wr, input logic [31:0] addr,
                           input logic [4:0] len, input logic [2:0] size);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    sample();
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_cmd cmd_ready got %b want 1", cmd_ready);
    end
    next_cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    next_cycle();
    sample();
    n_vec++;
    if ({Htrans, Haddr, Hsize, Hwrite, Hwdata} !== {2'b00, 32'h0, 3'd0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_bus got %h want 0", {Htrans, Haddr, Hsize, Hwrite, Hwdata});
    end
    n_vec++;
    if ({rd_data, rd_valid, wr_ready, err, busy, cmd_ready} !== {32'h0, 5'b00001}) begin
      n_err++;
      $display("FAIL reset_ctrl got %h want %h", {rd_data, rd_valid, wr_ready, err, busy, cmd_ready},
               {32'h0, 5'b00001});
    end
`ifdef AHB_MASTER_STATS_EN
    n_vec++;
    if ({beat_count, err_count} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_stats got %h want 0", {beat_count, err_count});
    end
`endif
    next_cycle();
    Hresetn = 1'b1;
  endtask

  task automatic test_single_write();
    wr_data = 32'hDEADBEEF;
    issue_cmd(1'b1, 32'h0000_0104, 5'd1, 3'd2);
    sample();
    n_vec++;
    if ({Htrans, Haddr, Hwrite, Hsize} !== {2'b10, 32'h104, 1'b1, 3'd2}) begin
      n_err++;
      $display("FAIL sw_addr got %h want %h", {Htrans, Haddr, Hwrite, Hsize}, {2'b10, 32'h104, 1'b1, 3'd2});
    end
    n_vec++;
    if ({wr_ready, busy, cmd_ready} !== 3'b110) begin
      n_err++;
      $display("FAIL sw_ctrl got %b want 110", {wr_ready, busy, cmd_ready});
    end
    next_cycle();
    wr_data = 32'h0;
    sample();
    n_vec++;
    if ({Htrans, busy} !== 3'b001) begin
      n_err++;
      $display("FAIL sw_last got %b want 001", {Htrans, busy});
    end
    n_vec++;
    if (Hwdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL sw_hwdata got %h want deadbeef", Hwdata);
    end
    next_cycle();
    sample();
    n_vec++;
    if ({busy, cmd_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL sw_done got %b want 01", {busy, cmd_ready});
    end
    next_cycle();
  endtask

  task automatic test_incr4_read();
    logic [31:0] rtbl [4];
    logic [1:0]  exp_tr;
    logic        exp_v;
    int          nvalid;
    rtbl[0] = 32'h11; rtbl[1] = 32'h22; rtbl[2] = 32'h33; rtbl[3] = 32'h44;
    nvalid = 0;
    issue_cmd(1'b0, 32'h200, 5'd4, 3'd2);
    for (int i = 0; i < 7; i++) begin
      if (i >= 1 && i <= 4) Hrdata = rtbl[i-1];
      else Hrdata = 32'h0;
      sample();
      if (i < 4) begin
        exp_tr = (i == 0) ? 2'b10 : 2'b11;
        n_vec++;
        if ({Htrans, Haddr} !== {exp_tr, 32'h200 + 32'(4 * i)}) begin
          n_err++;
          $display("FAIL rd4_addr beat %0d got %h want %h", i, {Htrans, Haddr}, {exp_tr, 32'h200 + 32'(4 * i)});
        end
      end else if (i == 4) begin
        n_vec++;
        if (Htrans !== 2'b00) begin
          n_err++;
          $display("FAIL rd4_last Htrans got %b want 00", Htrans);
        end
      end
      exp_v = (i >= 2 && i <= 5);
      n_vec++;
      if (rd_valid !== exp_v) begin
        n_err++;
        $display("FAIL rd4_valid cycle %0d got %b want %b", i, rd_valid, exp_v);
      end
      if (rd_valid === 1'b1 && nvalid < 4) begin
        n_vec++;
        if (rd_data !== rtbl[nvalid]) begin
          n_err++;
          $display("FAIL rd4_data %0d got %h want %h", nvalid, rd_data, rtbl[nvalid]);
        end
        nvalid++;
      end
      next_cycle();
    end
  endtask

  task automatic test_write_stall();
    logic [31:0] wtbl [4];
    int          rdy_tbl [9];
    logic [1:0]  tr_tbl [9];
    logic [31:0] ad_tbl [7];
    int          wd_idx [9];
    logic        wr_tbl [9];
    int          npulse;
    wtbl[0] = 32'hA1A1_0001; wtbl[1] = 32'hB2B2_0002; wtbl[2] = 32'hC3C3_0003; wtbl[3] = 32'hD4D4_0004;
    rdy_tbl = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    tr_tbl  = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    ad_tbl  = '{32'h200, 32'h204, 32'h208, 32'h208, 32'h208, 32'h208, 32'h20C};
    wd_idx  = '{-1, 0, 1, 1, 1, 1, 2, 3, -1};
    wr_tbl  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    npulse = 0;
    issue_cmd(1'b1, 32'h200, 5'd4, 3'd2);
    for (int i = 0; i < 9; i++) begin
      Hready = (rdy_tbl[i] != 0);
      wr_data = (npulse < 4) ? wtbl[npulse] : 32'h0;
      sample();
      n_vec++;
      if (Htrans !== tr_tbl[i]) begin
        n_err++;
        $display("FAIL ws_htrans cycle %0d got %b want %b", i, Htrans, tr_tbl[i]);
      end
      if (i < 7) begin
        n_vec++;
        if (Haddr !== ad_tbl[i]) begin
          n_err++;
          $display("FAIL ws_haddr cycle %0d got %h want %h", i, Haddr, ad_tbl[i]);
        end
      end
      if (wd_idx[i] >= 0) begin
        n_vec++;
        if (Hwdata !== wtbl[wd_idx[i]]) begin
          n_err++;
          $display("FAIL ws_hwdata cycle %0d got %h want %h", i, Hwdata, wtbl[wd_idx[i]]);
        end
      end
      n_vec++;
      if (wr_ready !== wr_tbl[i]) begin
        n_err++;
        $display("FAIL ws_wr_ready cycle %0d got %b want %b", i, wr_ready, wr_tbl[i]);
      end
      if (wr_ready === 1'b1) npulse++;
      next_cycle();
    end
    Hready = 1'b1;
    wr_data = 32'h0;
    n_vec++;
    if (npulse != 4) begin
      n_err++;
      $display("FAIL ws_pulses got %0d want 4", npulse);
    end
  endtask

  task automatic test_1k_boundary();
    logic [1:0]  tr_tbl [5];
    logic [31:0] ad_tbl [4];
    tr_tbl = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b00};
    ad_tbl = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
    issue_cmd(1'b0, 32'h3F8, 5'd4, 3'd2);
    for (int i = 0; i < 6; i++) begin
      sample();
      if (i < 4) begin
        n_vec++;
        if ({Htrans, Haddr} !== {tr_tbl[i], ad_tbl[i]}) begin
          n_err++;
          $display("FAIL kb_beat %0d got %h want %h", i, {Htrans, Haddr}, {tr_tbl[i], ad_tbl[i]});
        end
      end else if (i == 4) begin
        n_vec++;
        if (Htrans !== tr_tbl[4]) begin
          n_err++;
          $display("FAIL kb_last Htrans got %b want 00", Htrans);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_clamp();
    int   nbeats;
    int   nrv;
    logic done;
    // len 0 -> one beat, size 7 -> word, address aligned down.
    issue_cmd(1'b0, 32'h13, 5'd0, 3'd7);
    sample();
    n_vec++;
    if ({Htrans, Haddr, Hsize} !== {2'b10, 32'h10, 3'd2}) begin
      n_err++;
      $display("FAIL cl_single got %h want %h", {Htrans, Haddr, Hsize}, {2'b10, 32'h10, 3'd2});
    end
    next_cycle();
    sample();
    n_vec++;
    if ({Htrans, busy} !== 3'b001) begin
      n_err++;
      $display("FAIL cl_single_last got %b want 001", {Htrans, busy});
    end
    next_cycle();
    next_cycle();
    // len 20 clamps to 16 beats.
    nbeats = 0;
    nrv = 0;
    done = 1'b0;
    issue_cmd(1'b0, 32'h0, 5'd20, 3'd0);
    for (int i = 0; i < 40 && !done; i++) begin
      sample();
      if (Htrans[1] === 1'b1) nbeats++;
      if (rd_valid === 1'b1) nrv++;
      if (busy === 1'b0) done = 1'b1;
      next_cycle();
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL cl_timeout busy got %b want 0 within 40 cycles", busy);
    end
    n_vec++;
    if (nbeats != 16) begin
      n_err++;
      $display("FAIL cl_beats got %0d want 16", nbeats);
    end
    n_vec++;
    if (nrv != 16) begin
      n_err++;
      $display("FAIL cl_rd_valid got %0d want 16", nrv);
    end
  endtask

  task automatic test_error();
`ifdef AHB_MASTER_STATS_EN
    stats_clr = 1'b1;
    next_cycle();
    stats_clr = 1'b0;
    sample();
    n_vec++;
    if ({beat_count, err_count} !== 24'h0) begin
      n_err++;
      $display("FAIL er_clr got %h want 0", {beat_count, err_count});
    end
    next_cycle();
`endif
    issue_cmd(1'b0, 32'h100, 5'd8, 3'd2);
    sample();
    n_vec++;
    if ({Htrans, Haddr} !== {2'b10, 32'h100}) begin
      n_err++;
      $display("FAIL er_beat0 got %h want %h", {Htrans, Haddr}, {2'b10, 32'h100});
    end
    next_cycle();
    Hrdata = 32'hA0;
    sample();
    n_vec++;
    if ({Htrans, Haddr} !== {2'b11, 32'h104}) begin
      n_err++;
      $display("FAIL er_beat1 got %h want %h", {Htrans, Haddr}, {2'b11, 32'h104});
    end
    next_cycle();
    Hrdata = 32'hBAD;
    Hready = 1'b0;
    Hresp  = 2'b01;
    sample();
    n_vec++;
    if ({rd_valid, rd_data, err} !== {1'b1, 32'hA0, 1'b0}) begin
      n_err++;
      $display("FAIL er_first_data got %h want %h", {rd_valid, rd_data, err}, {1'b1, 32'hA0, 1'b0});
    end
    next_cycle();
    Hready = 1'b1;
    sample();
    n_vec++;
    if ({Htrans, busy, err, rd_valid} !== 5'b00100) begin
      n_err++;
      $display("FAIL er_abort got %b want 00100", {Htrans, busy, err, rd_valid});
    end
    next_cycle();
    Hresp = 2'b00;
    Hrdata = 32'h0;
    sample();
    n_vec++;
    if ({Htrans, busy, cmd_ready, err, rd_valid} !== 6'b000110) begin
      n_err++;
      $display("FAIL er_pulse got %b want 000110", {Htrans, busy, cmd_ready, err, rd_valid});
    end
    next_cycle();
    sample();
    n_vec++;
    if ({Htrans, err, rd_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL er_after got %b want 0000", {Htrans, err, rd_valid});
    end
`ifdef AHB_MASTER_STATS_EN
    n_vec++;
    if ({beat_count, err_count} !== {16'd1, 8'd1}) begin
      n_err++;
      $display("FAIL er_stats got %h want %h", {beat_count, err_count}, {16'd1, 8'd1});
    end
`endif
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    issue_cmd(1'b0, 32'h300, 5'd4, 3'd2);
    sample();
    n_vec++;
    if (Htrans !== 2'b10) begin
      n_err++;
      $display("FAIL rm_start Htrans got %b want 10", Htrans);
    end
    next_cycle();
    Hresetn = 1'b0;
    next_cycle();
    Hresetn = 1'b1;
    sample();
    n_vec++;
    if ({Htrans, cmd_ready, busy} !== 4'b0010) begin
      n_err++;
      $display("FAIL rm_after got %b want 0010", {Htrans, cmd_ready, busy});
    end
    next_cycle();
    // A halfword write after reset: start address aligned, step of 2.
    wr_data = 32'h5555_AAAA;
    issue_cmd(1'b1, 32'h41, 5'd2, 3'd1);
    sample();
    n_vec++;
    if ({Htrans, Haddr, Hsize, Hwrite, wr_ready} !== {2'b10, 32'h40, 3'd1, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL rm_new0 got %h want %h", {Htrans, Haddr, Hsize, Hwrite, wr_ready},
               {2'b10, 32'h40, 3'd1, 1'b1, 1'b1});
    end
    next_cycle();
    wr_data = 32'h0000_1234;
    sample();
    n_vec++;
    if ({Htrans, Haddr, Hwdata, wr_ready} !== {2'b11, 32'h42, 32'h5555_AAAA, 1'b1}) begin
      n_err++;
      $display("FAIL rm_new1 got %h want %h", {Htrans, Haddr, Hwdata, wr_ready},
               {2'b11, 32'h42, 32'h5555_AAAA, 1'b1});
    end
    next_cycle();
    wr_data = 32'h0;
    sample();
    n_vec++;
    if ({Htrans, Hwdata} !== {2'b00, 32'h0000_1234}) begin
      n_err++;
      $display("FAIL rm_last got %h want %h", {Htrans, Hwdata}, {2'b00, 32'h0000_1234});
    end
    next_cycle();
    sample();
    n_vec++;
    if ({busy, cmd_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL rm_done got %b want 01", {busy, cmd_ready});
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr4_read();
    test_write_stall();
    test_1k_boundary();
    test_clamp();
    test_error();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
